io_channel_unit: RTL and testbench
==================================

# io_channel_unit

Peripheral-side responder for the core's I/O channel interface. Decodes the core's 3-bit `IO_write_sel`/`IO_read_sel` channel selects and implements eight 15-bit channels:
- four output latches;
- a transmit FIFO toward an external display/telemetry device;
- a receive FIFO from an external keyboard/uplink;
- a status/control register;
- a free-running prescaled timer with overflow interrupt.

It sits outside the core, between the core's I/O ports and the external devices.

## Interface
Parameters:
- `TX_DEPTH`, 4: transmit FIFO entries; power of two, ≥2.
- `RX_DEPTH`, 4: receive FIFO entries; power of two, ≥2.
- `TIMER_DIV`, 16: clock cycles per timer increment; ≥1.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `IO_read_sel`  in  3  channel being read.
- `IO_read_en`  in  1  read commit strobe; qualifies pop side effects.
- `IO_read_data`  out  15  combinational read data for `IO_read_sel`.
- `IO_write_sel`  in  3  channel being written.
- `IO_write_data`  in  15  write data.
- `IO_write_en`  in  1  write strobe.
- `out_ch`  out  60  output latches; ch N at bits [15N+14:15N], N=0..3.
- `tx_data`  out  15  TX FIFO head.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  external device accepts head.
- `rx_data`  in  15  incoming word.
- `rx_valid`  in  1  incoming word valid.
- `rx_ready`  out  1  RX FIFO not full.
- `timer_irq`  out  1  sticky timer overflow flag.

## Operation
- **Ch 0–3 (output latches)**
  - Write loads the selected latch.
  - Read returns the latch value.
- **Ch 4 (TX FIFO)**
  - Write pushes `IO_write_data`.
  - Write while full: word dropped, `tx_ovf` set.
  - Read returns `{12'b0, tx_count[2:0]}`, with count saturated to 3 bits.
  - External pop on `tx_valid & tx_ready`.
- **Ch 5 (RX FIFO)**
  - Read returns the head, or 0 if empty.
  - Read with `IO_read_en=1` on a non-empty FIFO pops the head.
  - Write flushes the FIFO (count←0, pointers←0).
  - External push on `rx_valid & rx_ready`.
- **Ch 6 (status)**
  - Read: bit0 = RX non-empty, bit1 = TX full, bit2 = `tx_ovf`, bit3 = `timer_irq`; bits 14:4 = 0.
  - Write: write-1-to-clear on bits 2 and 3; other bits ignored.
- **Ch 7 (timer)**
  - 15-bit counter; prescaler counts 0..TIMER_DIV-1.
  - On prescaler wrap, the counter increments.
  - Counter increment from 'o77777 → 0 sets `timer_irq`.
  - Write loads the counter and clears the prescaler.
  - Read returns the counter.
- **Outputs and arithmetic**
  - `tx_valid = (tx_count != 0)`.
  - `rx_ready = (rx_count != RX_DEPTH)`.
  - `tx_data` = TX head.
  - Counts are `$clog2(DEPTH)+1` bits; pointers wrap modulo DEPTH.
- **Simultaneous events**
  - TX push + external pop while full: both occur, count unchanged, no overflow.
  - RX push + core pop while full: `rx_ready`=0, so only the pop occurs.
  - RX push + core pop while not full: count unchanged.
  - Ch 5 flush + external push in the same cycle: flush wins, pushed word is discarded.
  - Status W1C of bit 3 in the same cycle as a timer overflow: set wins. Same rule for bit 2 vs a new TX overflow.
  - Ch 7 write in the same cycle as a timer increment: write wins, no increment, no irq from that tick.
  - Same channel read and written in one cycle: read returns the pre-write value; the write takes effect after the edge.

## Timing
- `IO_read_data` is combinational from `IO_read_sel` and current state (zero-cycle latency), so the core samples it in the same cycle.
- Writes, pops, pushes and flushes take effect at the rising edge where the strobe is sampled.
- TX write → `tx_valid` high the next cycle (1-cycle latency).
- External RX push → ch 5 readable the next cycle.
- Timer: first increment occurs TIMER_DIV cycles after reset or after a ch 7 write.
- Reset (asynchronous, at any time, including mid-transfer): all latches, FIFO storage, counts, pointers, `tx_ovf`, timer, prescaler and `timer_irq` go to 0.
- Resulting reset output values:
  - `out_ch`=0, `tx_data`=0, `tx_valid`=0, `rx_ready`=1, `timer_irq`=0.
  - `IO_read_data`=0 for every select.

## Test plan
- Reset, then write ch2 ← 'o12345 → `out_ch[44:30]`='o12345 next cycle; ch2 reads 'o12345; other latches stay 0.
- With `tx_ready`=0, write ch4 five times (1..5), TX_DEPTH=4 → ch4 reads 4, ch6 bit1=1, bit2=1. Raise `tx_ready` → `tx_data` sequence 1,2,3,4, then `tx_valid`=0. Write ch6 ← 'o4 → bit2=0.
- Push rx 'o7, 'o11 via `rx_valid` → ch6 bit0=1. Read ch5 with `IO_read_en`=0 → 'o7, no pop. Two reads with en=1 → 'o7 then 'o11; then empty, reads 0.
- Fill RX to 4 → `rx_ready`=0. Hold `rx_valid`=1 and pop once → exactly one new word accepted on the following cycle, count back to 4.
- Write ch7 ← 'o77776, TIMER_DIV=16 → counter 'o77777 after 16 cycles; after 32 cycles counter 0 and `timer_irq`=1. W1C in the same cycle as the next overflow → irq stays 1.
- Assert `reset` mid-burst with TX holding 3 words → `tx_valid`, `out_ch`, `timer_irq` drop to 0 immediately, before the next clock edge; `rx_ready`=1.

Source files
------------

// File: rtl/io_channel_unit.sv
// Peripheral-side responder for the core's 3-bit I/O channel selects: four output
// latches, TX/RX FIFOs, a status/W1C register and a prescaled free-running timer.
module io_channel_unit #(
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4,
  parameter int TIMER_DIV = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  IO_read_sel,
  input  logic        IO_read_en,
  output logic [14:0] IO_read_data,
  input  logic [2:0]  IO_write_sel,
  input  logic [14:0] IO_write_data,
  input  logic        IO_write_en,
  output logic [59:0] out_ch,
  output logic [14:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [14:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        timer_irq
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;
  localparam int PSW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(TIMER_DIV - 1);

  logic [14:0]    r_outCh [4];
  logic [14:0]    r_txMem [TX_DEPTH];
  logic [TPW-1:0] r_txWr, r_txRd;
  logic [TCW-1:0] r_txCount;
  logic           r_txOvf;
  logic [14:0]    r_rxMem [RX_DEPTH];
  logic [RPW-1:0] r_rxWr, r_rxRd;
  logic [RCW-1:0] r_rxCount;
  logic [14:0]    r_timer;
  logic [PSW-1:0] r_presc;
  logic           r_timerIrq;

  logic       w_txWrite, w_txFull, w_txPop, w_txPush, w_txOvfSet;
  logic       w_rxFlush, w_rxEmpty, w_rxPush, w_rxPop;
  logic       w_statWr, w_timerWr, w_tick, w_timerOvf;
  logic [2:0] w_txCountSat;

  assign w_txWrite  = IO_write_en && (IO_write_sel == 3'd4);
  assign w_txFull   = (r_txCount == TCW'(TX_DEPTH));
  assign w_txPop    = tx_valid && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_txPush   = w_txWrite && (!w_txFull || w_txPop);
  assign w_txOvfSet = w_txWrite && w_txFull && !w_txPop;

  assign w_rxFlush  = IO_write_en && (IO_write_sel == 3'd5);
  assign w_rxEmpty  = (r_rxCount == '0);
  assign w_rxPush   = rx_valid && rx_ready && !w_rxFlush;
  assign w_rxPop    = IO_read_en && (IO_read_sel == 3'd5) && !w_rxEmpty && !w_rxFlush;

  assign w_statWr   = IO_write_en && (IO_write_sel == 3'd6);
  assign w_timerWr  = IO_write_en && (IO_write_sel == 3'd7);
  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_timerOvf = w_tick && !w_timerWr && (r_timer == 15'h7fff);

  assign tx_valid  = (r_txCount != '0);
  assign tx_data   = r_txMem[r_txRd];
  assign rx_ready  = (r_rxCount != RCW'(RX_DEPTH));
  assign timer_irq = r_timerIrq;

  for (genvar g = 0; g < 4; g++) begin : g_outCh
    assign out_ch[15*g +: 15] = r_outCh[g];
  end

  if (TCW > 3) begin : g_satWide
    assign w_txCountSat = (|r_txCount[TCW-1:3]) ? 3'd7 : r_txCount[2:0];
  end else begin : g_satNarrow
    assign w_txCountSat = 3'(r_txCount);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_outCh[i] <= '0;
    end else if (IO_write_en && !IO_write_sel[2]) begin
      r_outCh[IO_write_sel[1:0]] <= IO_write_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TX_DEPTH; i++) r_txMem[i] <= '0;
      r_txWr    <= '0;
      r_txRd    <= '0;
      r_txCount <= '0;
    end else begin
      if (w_txPush) begin
        r_txMem[r_txWr] <= IO_write_data;
        r_txWr          <= r_txWr + TPW'(1);
      end
      if (w_txPop) r_txRd <= r_txRd + TPW'(1);
      case ({w_txPush, w_txPop})
        2'b10:   r_txCount <= r_txCount + TCW'(1);
        2'b01:   r_txCount <= r_txCount - TCW'(1);
        default: r_txCount <= r_txCount;
      endcase
    end
  end

  // Sticky flags: a new set event in the same cycle beats the W1C.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_txOvf    <= 1'b0;
      r_timerIrq <= 1'b0;
    end else begin
      if (w_txOvfSet)                        r_txOvf <= 1'b1;
      else if (w_statWr && IO_write_data[2]) r_txOvf <= 1'b0;
      if (w_timerOvf)                        r_timerIrq <= 1'b1;
      else if (w_statWr && IO_write_data[3]) r_timerIrq <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RX_DEPTH; i++) r_rxMem[i] <= '0;
      r_rxWr    <= '0;
      r_rxRd    <= '0;
      r_rxCount <= '0;
    end else if (w_rxFlush) begin
      r_rxWr    <= '0;
      r_rxRd    <= '0;
      r_rxCount <= '0;
    end else begin
      if (w_rxPush) begin
        r_rxMem[r_rxWr] <= rx_data;
        r_rxWr          <= r_rxWr + RPW'(1);
      end
      if (w_rxPop) r_rxRd <= r_rxRd + RPW'(1);
      case ({w_rxPush, w_rxPop})
        2'b10:   r_rxCount <= r_rxCount + RCW'(1);
        2'b01:   r_rxCount <= r_rxCount - RCW'(1);
        default: r_rxCount <= r_rxCount;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
      r_presc <= '0;
    end else if (w_timerWr) begin
      r_timer <= IO_write_data;
      r_presc <= '0;
    end else if (w_tick) begin
      r_timer <= r_timer + 15'd1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PSW'(1);
    end
  end

  always_comb begin
    IO_read_data = '0;
    case (IO_read_sel)
      3'd0, 3'd1, 3'd2, 3'd3: IO_read_data = r_outCh[IO_read_sel[1:0]];
      3'd4:    IO_read_data = {12'b0, w_txCountSat};
      3'd5:    IO_read_data = w_rxEmpty ? 15'd0 : r_rxMem[r_rxRd];
      3'd6:    IO_read_data = {11'b0, r_timerIrq, r_txOvf, w_txFull, !w_rxEmpty};
      3'd7:    IO_read_data = r_timer;
      default: IO_read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_io_channel_unit.sv
// Self-checking bench for io_channel_unit: queue-based channel model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_io_channel_unit;

  localparam int TX_DEPTH  = 4;
  localparam int RX_DEPTH  = 4;
  localparam int TIMER_DIV = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  IO_read_sel = '0;
  logic        IO_read_en = 1'b0;
  logic [14:0] IO_read_data;
  logic [2:0]  IO_write_sel = '0;
  logic [14:0] IO_write_data = '0;
  logic        IO_write_en = 1'b0;
  logic [59:0] out_ch;
  logic [14:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [14:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        timer_irq;

  io_channel_unit #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .TIMER_DIV(TIMER_DIV)) dut (
    .clock(clock), .reset(reset),
    .IO_read_sel(IO_read_sel), .IO_read_en(IO_read_en), .IO_read_data(IO_read_data),
    .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data), .IO_write_en(IO_write_en),
    .out_ch(out_ch), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .timer_irq(timer_irq)
  );

  always #10 clock = ~clock;

  int nChecks = 0;
  int nFail   = 0;
  bit cmpEn   = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel model: plain queues and counters, advanced once per clock edge.
  logic [14:0] mOut [4];
  logic [14:0] mTx [$];
  logic [14:0] mRx [$];
  bit          mOvf, mIrq;
  int          mTimer, mPresc;
  bit          newOvf, newIrq, txPop, rxOk, rxPop;

  initial begin
    for (int i = 0; i < 4; i++) mOut[i] = '0;
    mOvf = 0; mIrq = 0; mTimer = 0; mPresc = 0;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mOut[i] = '0;
      mTx.delete();
      mRx.delete();
      mOvf = 0; mIrq = 0; mTimer = 0; mPresc = 0;
    end else begin
      newOvf = 0;
      newIrq = 0;
      txPop  = (mTx.size() > 0) && tx_ready;
      rxOk   = (mRx.size() != RX_DEPTH);
      rxPop  = IO_read_en && (IO_read_sel == 3'd5) && (mRx.size() > 0);
      if (txPop) void'(mTx.pop_front());
      if (IO_write_en && IO_write_sel == 3'd4) begin
        if (mTx.size() < TX_DEPTH) mTx.push_back(IO_write_data);
        else newOvf = 1;
      end
      if (IO_write_en && IO_write_sel < 3'd4) mOut[IO_write_sel[1:0]] = IO_write_data;
      if (IO_write_en && IO_write_sel == 3'd5) begin
        mRx.delete();
      end else begin
        if (rxPop) void'(mRx.pop_front());
        if (rx_valid && rxOk) mRx.push_back(rx_data);
      end
      if (IO_write_en && IO_write_sel == 3'd7) begin
        mTimer = int'(IO_write_data);
        mPresc = 0;
      end else begin
        mPresc++;
        if (mPresc == TIMER_DIV) begin
          mPresc = 0;
          mTimer = (mTimer + 1) % 32768;
          if (mTimer == 0) newIrq = 1;
        end
      end
      if (IO_write_en && IO_write_sel == 3'd6 && IO_write_data[2]) mOvf = 0;
      if (IO_write_en && IO_write_sel == 3'd6 && IO_write_data[3]) mIrq = 0;
      if (newOvf) mOvf = 1;
      if (newIrq) mIrq = 1;
    end
  end

  function automatic logic [14:0] modelRead(input logic [2:0] sel);
    case (sel)
      3'd4:    return 15'((mTx.size() > 7) ? 7 : mTx.size());
      3'd5:    return (mRx.size() > 0) ? mRx[0] : 15'd0;
      3'd6:    return {11'b0, mIrq, mOvf, mTx.size() == TX_DEPTH, mRx.size() != 0};
      3'd7:    return 15'(mTimer);
      default: return mOut[sel[1:0]];
    endcase
  endfunction

  always @(negedge clock) begin
    if (cmpEn) begin
      checkOutput("model out_ch", out_ch, {mOut[3], mOut[2], mOut[1], mOut[0]});
      checkOutput("model tx_valid", tx_valid, mTx.size() != 0);
      if (mTx.size() != 0) checkOutput("model tx_data", tx_data, mTx[0]);
      checkOutput("model rx_ready", rx_ready, mRx.size() != RX_DEPTH);
      checkOutput("model timer_irq", timer_irq, mIrq);
      checkOutput("model read_data", IO_read_data, modelRead(IO_read_sel));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [14:0] data);
    IO_write_sel  = sel;
    IO_write_data = data;
    IO_write_en   = 1'b1;
    tick();
    IO_write_en   = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [2:0] sel, input logic [14:0] exp);
    IO_read_sel = sel;
    #1;
    checkOutput(name, IO_read_data, exp);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    checkOutput("reset out_ch", out_ch, 0);
    checkOutput("reset tx_valid", tx_valid, 0);
    checkOutput("reset tx_data", tx_data, 0);
    checkOutput("reset rx_ready", rx_ready, 1);
    checkOutput("reset timer_irq", timer_irq, 0);
    for (int s = 0; s < 8; s++) readCheck("reset read", 3'(s), 15'd0);
    cmpEn = 1'b1;
    @(negedge clock);
    #2 reset = 1'b0;
    tick();

    // Output latches
    applyStimulus(3'd2, 15'o12345);
    checkOutput("ch2 latch", out_ch[44:30], 15'o12345);
    checkOutput("other latches", {out_ch[59:45], out_ch[29:0]}, 0);
    readCheck("ch2 read", 3'd2, 15'o12345);
    readCheck("ch0 read", 3'd0, 15'd0);

    // TX overflow then drain
    for (int i = 1; i <= 5; i++) applyStimulus(3'd4, 15'(i));
    readCheck("tx count full", 3'd4, 15'd4);
    readCheck("tx full+ovf", 3'd6, 15'o6);
    tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("tx head", tx_data, k);
      checkOutput("tx valid", tx_valid, 1);
      tick();
    end
    checkOutput("tx drained", tx_valid, 0);
    tx_ready = 1'b0;
    applyStimulus(3'd6, 15'o4);
    readCheck("ovf cleared", 3'd6, 15'd0);

    // RX push, peek, pop
    rx_valid = 1'b1;
    rx_data  = 15'o7;
    tick();
    rx_data  = 15'o11;
    tick();
    rx_valid = 1'b0;
    readCheck("rx nonempty", 3'd6, 15'd1);
    readCheck("rx peek", 3'd5, 15'o7);
    tick();
    readCheck("rx no pop", 3'd5, 15'o7);
    IO_read_en = 1'b1;
    readCheck("rx pop1", 3'd5, 15'o7);
    tick();
    readCheck("rx pop2", 3'd5, 15'o11);
    tick();
    IO_read_en = 1'b0;
    readCheck("rx empty", 3'd5, 15'd0);
    readCheck("rx empty status", 3'd6, 15'd0);

    // RX full, push held while popping
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 15'(8'o100 + i);
      tick();
    end
    checkOutput("rx full ready", rx_ready, 0);
    rx_data = 15'o200;
    tick();
    checkOutput("rx held", rx_ready, 0);
    IO_read_en = 1'b1;
    readCheck("rx full head", 3'd5, 15'o100);
    tick();
    IO_read_en = 1'b0;
    checkOutput("rx room", rx_ready, 1);
    readCheck("rx next head", 3'd5, 15'o101);
    tick();
    checkOutput("rx refilled", rx_ready, 0);
    rx_data = 15'o300;
    applyStimulus(3'd5, 15'd0);
    rx_valid = 1'b0;
    readCheck("flush status", 3'd6, 15'd0);
    readCheck("flush read", 3'd5, 15'd0);
    checkOutput("flush ready", rx_ready, 1);

    // Timer wrap and W1C race
    applyStimulus(3'd7, 15'o77776);
    repeat (15) tick();
    readCheck("timer hold", 3'd7, 15'o77776);
    tick();
    readCheck("timer inc", 3'd7, 15'o77777);
    repeat (15) tick();
    checkOutput("irq before wrap", timer_irq, 0);
    tick();
    readCheck("timer wrap", 3'd7, 15'd0);
    checkOutput("irq set", timer_irq, 1);
    readCheck("irq status", 3'd6, 15'o10);
    applyStimulus(3'd7, 15'o77777);
    repeat (15) tick();
    applyStimulus(3'd6, 15'o10);
    checkOutput("irq set wins", timer_irq, 1);
    applyStimulus(3'd6, 15'o10);
    checkOutput("irq cleared", timer_irq, 0);

    // TX push and pop together while full
    for (int i = 0; i < 4; i++) applyStimulus(3'd4, 15'(8'o21 + i));
    tx_ready = 1'b1;
    applyStimulus(3'd4, 15'o25);
    tx_ready = 1'b0;
    readCheck("tx full swap count", 3'd4, 15'd4);
    readCheck("tx full swap status", 3'd6, 15'o2);
    checkOutput("tx full swap head", tx_data, 15'o22);

    // Asynchronous reset mid-burst
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    readCheck("tx three", 3'd4, 15'd3);
    applyStimulus(3'd7, 15'o77777);
    repeat (16) tick();
    checkOutput("irq pre-reset", timer_irq, 1);
    applyStimulus(3'd0, 15'o777);
    #2 reset = 1'b1;
    #1;
    checkOutput("async tx_valid", tx_valid, 0);
    checkOutput("async out_ch", out_ch, 0);
    checkOutput("async irq", timer_irq, 0);
    checkOutput("async rx_ready", rx_ready, 1);
    readCheck("async tx count", 3'd4, 15'd0);
    @(negedge clock);
    #3 reset = 1'b0;
    tick();
    applyStimulus(3'd3, 15'o4321);
    checkOutput("post-reset latch", out_ch[59:45], 15'o4321);
    readCheck("post-reset timer", 3'd7, 15'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
